// File: rtl/sram_arbiter_if.sv
// Requester-side bus of sram_arbiter: instruction-fetch read port and data read/write port.
// master = requesters, slave = arbiter.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    input  if_ack, if_done, if_rdata, d_ack, d_done, d_rdata
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    output if_ack, if_done, if_rdata, d_ack, d_done, d_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-ported SRAM, 3 cycles per access.
// Define SRAM_ARB_RR_EN for round-robin on collisions; default is fixed priority to the data port.
module sram_arbiter #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we,
  output logic              sram_re,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e            state_q;
  logic              gnt_d_q;  // current owner is the data port
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              sram_we_q, sram_re_q;
  logic              if_ack_q, d_ack_q, if_done_q, d_done_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic              any_req;
  logic              gnt_d;

  assign any_req = bus.if_req | bus.d_req;

`ifdef SRAM_ARB_RR_EN
  logic last_d_q;

  always_comb begin
    gnt_d = bus.d_req;
    if (bus.if_req && bus.d_req) gnt_d = ~last_d_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_q <= 1'b0;
    end else if (state_q == StIdle && any_req) begin
      last_d_q <= gnt_d;
    end
  end
`else
  always_comb begin
    gnt_d = bus.d_req;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_d_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sram_we_q  <= 1'b0;
      sram_re_q  <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q   <= StAccess;
            gnt_d_q   <= gnt_d;
            addr_q    <= gnt_d ? bus.d_addr : bus.if_addr;
            wdata_q   <= bus.d_wdata;
            sram_we_q <= gnt_d & bus.d_we;
            sram_re_q <= ~(gnt_d & bus.d_we);
            if_ack_q  <= ~gnt_d;
            d_ack_q   <= gnt_d;
          end
        end
        StAccess: begin
          state_q   <= StDone;
          sram_we_q <= 1'b0;
          sram_re_q <= 1'b0;
          if_ack_q  <= 1'b0;
          d_ack_q   <= 1'b0;
          if_done_q <= ~gnt_d_q;
          d_done_q  <= gnt_d_q;
          // Read data is captured on the edge that ends ACCESS.
          if (sram_re_q) begin
            if (gnt_d_q) d_rdata_q <= sram_data;
            else         if_rdata_q <= sram_data;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          if_done_q <= 1'b0;
          d_done_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sram_addr    = addr_q;
  assign sram_we      = sram_we_q;
  assign sram_re      = sram_re_q;
  assign sram_data    = sram_we_q ? wdata_q : {DATA_W{1'bz}};
  assign busy         = (state_q != StIdle);

  assign bus.if_ack   = if_ack_q;
  assign bus.if_done  = if_done_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.d_done   = d_done_q;
  assign bus.d_rdata  = d_rdata_q;

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, SRAM data width.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port if_req  in  1  instruction-fetch read request, held until if_ack.
REQ-006 SHALL have port if_addr  in  ADDR_W  fetch address.
REQ-007 SHALL have ports if_ack, if_done  out  1 each  fetch accept pulse / completion pulse.
REQ-008 SHALL have port if_rdata  out  DATA_W  fetch read data.
REQ-009 SHALL have ports d_req, d_we  in  1 each  data-port request, 1=write 0=read.
REQ-010 SHALL have ports d_addr  in  ADDR_W and d_wdata  in  DATA_W  data-port address / write data.
REQ-011 SHALL have ports d_ack, d_done  out  1 each and d_rdata  out  DATA_W  data-port accept / completion / read data.
REQ-012 SHALL have ports sram_addr  out  ADDR_W, sram_we  out  1, sram_re  out  1  SRAM control.
REQ-013 SHALL have port sram_data  inout  DATA_W  shared SRAM data bus.
REQ-014 SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, DONE; transitions IDLE->ACCESS when any req high, ACCESS->DONE, DONE->IDLE, unconditionally.
REQ-016 SHALL, on the IDLE->ACCESS edge, latch winning port id, address, we (0 for fetch) and wdata; request inputs are ignored in ACCESS and DONE.
REQ-017 SHALL assert the winner's ack (registered) for exactly the ACCESS cycle; requester deasserts req by the DONE cycle, any req high in IDLE is a new request.
REQ-018 SHALL, in ACCESS write: sram_we=1, sram_re=0, drive sram_data=latched wdata; SRAM commits on the edge ending ACCESS.
REQ-019 SHALL, in ACCESS read: sram_re=1, sram_we=0, sram_data released to Z; capture sram_data into the winner's rdata on the edge ending ACCESS.
REQ-020 SHALL, outside ACCESS: sram_we=0, sram_re=0, sram_data=Z, sram_addr holds last value.
REQ-021 SHALL never assert sram_we and sram_re together, and SHALL drive sram_data only when sram_we=1.
REQ-022 SHALL pulse the winner's done for exactly the DONE cycle; if_done/d_done never both high.
REQ-023 SHALL hold each port's rdata stable until that port's next read completes; writes do not alter d_rdata.
REQ-024 SHALL give latency: req sampled in IDLE cycle N -> ack cycle N+1 -> done/rdata valid cycle N+2; max one access per 3 cycles.
REQ-025 SHALL, with only one req high in IDLE, grant that port.

Reset
REQ-026 SHALL, on rst_n low (async, any state incl. mid-ACCESS), force IDLE, sram_we=0, sram_re=0, sram_data=Z, sram_addr=0, all ack/done=0, if_rdata=d_rdata=0, busy=0, last-grant pointer=IF.
REQ-027 SHALL leave SRAM contents undefined for a write interrupted by reset; no retry.

Configuration
REQ-028 SHALL, with SRAM_ARB_RR_EN defined, resolve simultaneous requests round-robin: grant the port not granted last; pointer updates on each grant.
REQ-029 SHALL, without SRAM_ARB_RR_EN, resolve simultaneous requests by fixed priority, data port always wins; pointer logic absent.

Verification
REQ-030 SHALL cover: d_req,d_we=1,d_addr=0x005,d_wdata=0xBEEF in IDLE -> d_ack N+1 with sram_we=1,sram_data=0xBEEF; d_done N+2.
REQ-031 SHALL cover: after REQ-030, if_req,if_addr=0x005 -> sram_re=1 in ACCESS, if_done N+2 with if_rdata=0xBEEF, d_rdata unchanged.
REQ-032 SHALL cover: if_req and d_req (read 0x001) held high together for 4 grants -> RR_EN: order D,IF,D,IF; without: D,D,D,D.
REQ-033 SHALL cover: rst_n low mid-ACCESS of write -> same-cycle sram_we=0, sram_data=Z, busy=0, no done pulse.
REQ-034 SHALL cover: continuous fetch reads 0x000..0x003 -> if_done every 3rd cycle, sram_we never 1, sram_we&sram_re never 1.
